dff_segment_serializer: RTL and testbench

Parametrised output serializer for the FFT output path. It accepts one block of DEPTH words in parallel with a valid/ready handshake and emits them serially, one word per cycle, under downstream backpressure. Words leave in natural or bit-reversed index order. It replaces fixed-depth hold/select DFF output chains, and sits between the last butterfly stage and the output port.

---
 rtl/dff_segment_serializer.sv | 110 +++++++++++
 tb/tb_dff_segment_serializer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/dff_segment_serializer.sv
// Block-parallel to word-serial output stage for the FFT output path.
// One DEPTH-word block is captured in a single handshake, then shifted out
// one word per accepted cycle from stage[0], in natural or bit-reversed order.

// One storage stage of the output shift register.
module dff_segment_stage #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         ld,
  input  logic         shift,
  input  logic [W-1:0] ld_data,
  input  logic [W-1:0] shift_data,
  output logic [W-1:0] q
);

  // Reset beats flush, flush beats load, and load beats shift.
  always_ff @(posedge clk) begin
    if (!rst)       q <= '0;
    else if (clr)   q <= '0;
    else if (ld)    q <= ld_data;
    else if (shift) q <= shift_data;
  end

endmodule

module dff_segment_serializer #(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 8,   // power of 2, >= 2
  localparam int CNT_W      = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        load_valid,
  output logic                        load_ready,
  input  logic                        load_bitrev,
  input  logic [DEPTH*DATA_WIDTH-1:0] load_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        out_last,
  output logic [CNT_W:0]              remaining
);

  localparam logic [CNT_W:0] FULL = (CNT_W+1)'(DEPTH);
  localparam logic [CNT_W:0] ONE  = (CNT_W+1)'(1);

  // Reverse the low CNT_W bits of an index; evaluated at elaboration only.
  function automatic int bitrev(input int k);
    int r;
    r = 0;
    for (int b = 0; b < CNT_W; b++)
      r = r | (((k >> b) & 1) << (CNT_W - 1 - b));
    return r;
  endfunction

  logic [DEPTH-1:0][DATA_WIDTH-1:0] stage_q;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] load_w;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] next_w;
  logic [CNT_W:0]                   rem_q;
  logic                             load_acc;
  logic                             out_acc;

  // A new block may enter when empty, or when the last word leaves this cycle,
  // so consecutive blocks stream with no bubble.
  assign load_ready = !flush && ((rem_q == '0) || ((rem_q == ONE) && out_ready));
  assign load_acc   = load_valid && load_ready;
  assign out_valid  = (rem_q != '0);
  assign out_acc    = out_valid && out_ready;
  assign out_last   = (rem_q == ONE);
  assign remaining  = rem_q;
  // Stages drain to zero behind the last word, so stage[0] is zero when empty.
  assign out_data   = stage_q[0];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    localparam int SRC = bitrev(k);

    assign load_w[k] = load_bitrev ? load_data[SRC*DATA_WIDTH +: DATA_WIDTH]
                                   : load_data[k*DATA_WIDTH +: DATA_WIDTH];

    if (k == DEPTH-1) begin : g_tail
      assign next_w[k] = '0;
    end else begin : g_body
      assign next_w[k] = stage_q[k+1];
    end

    dff_segment_stage #(.W(DATA_WIDTH)) u_stage (
      .clk       (clk),
      .rst       (rst),
      .clr       (flush),
      .ld        (load_acc),
      .shift     (out_acc),
      .ld_data   (load_w[k]),
      .shift_data(next_w[k]),
      .q         (stage_q[k])
    );
  end

  // Words left in the current block; a load reloads even on the last-word cycle.
  always_ff @(posedge clk) begin
    if (!rst)          rem_q <= '0;
    else if (flush)    rem_q <= '0;
    else if (load_acc) rem_q <= FULL;
    else if (out_acc)  rem_q <= rem_q - ONE;
  end

endmodule

// File: tb/tb_dff_segment_serializer.sv
// Scoreboard bench: the driver pushes each accepted block's expected word
// stream into a queue; the monitor compares the DUT against the queue head.
module tb_dff_segment_serializer;

  localparam int W     = 32;
  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH);

  typedef struct {
    logic [W-1:0] d;
    bit           last;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   flush = 1'b0;
  logic                   load_valid = 1'b0;
  logic                   load_ready;
  logic                   load_bitrev = 1'b0;
  logic [DEPTH*W-1:0]     load_data = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [W-1:0]           out_data;
  logic                   out_last;
  logic [CNT_W:0]         remaining;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   chk_en = 1'b0;

  dff_segment_serializer #(.DATA_WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_bitrev(load_bitrev),
    .load_data  (load_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .remaining  (remaining)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int rev(input int k);
    int r = 0;
    for (int b = 0; b < CNT_W; b++)
      if ((k / (1 << b)) % 2 == 1) r += 1 << (CNT_W - 1 - b);
    return r;
  endfunction

  function automatic logic [DEPTH*W-1:0] mk_seq(input logic [W-1:0] base);
    logic [DEPTH*W-1:0] d;
    for (int i = 0; i < DEPTH; i++) d[i*W +: W] = base + W'(i);
    return d;
  endfunction

  function automatic logic [DEPTH*W-1:0] mk_rand();
    logic [DEPTH*W-1:0] d;
    for (int i = 0; i < DEPTH; i++) d[i*W +: W] = $urandom;
    return d;
  endfunction

  // Drive one cycle of inputs, then update the model as of the coming edge.
  task automatic step(input bit lv, input bit br, input logic [DEPTH*W-1:0] d,
                      input bit ord, input bit fl, input bit rs);
    @(negedge clk);
    load_valid  = lv;
    load_bitrev = br;
    load_data   = d;
    out_ready   = ord;
    flush       = fl;
    rst         = rs;
    #2;
    // Monitor has already retired this cycle's accepted word at this point.
    if (!rs || fl) q.delete();
    else if (lv && q.size() == 0) begin
      for (int k = 0; k < DEPTH; k++) begin
        exp_t e;
        e.d    = d[(br ? rev(k) : k)*W +: W];
        e.last = (k == DEPTH-1);
        q.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
  endtask

  // Monitor: compare pre-edge DUT state with the model, retire accepted words.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (chk_en) begin
        int   rem;
        bit   ev, el, elr;
        logic [W-1:0] ed;
        rem = 0;
        for (int i = 0; i < q.size(); i++)
          if (q[i].last) begin rem = i + 1; break; end
        ev  = (rem != 0);
        el  = (rem == 1);
        ed  = ev ? q[0].d : '0;
        elr = !flush && (rem == 0 || (rem == 1 && out_ready));
        chk("out_valid",  W'(out_valid),  W'(ev));
        chk("out_data",   out_data,       ed);
        chk("out_last",   W'(out_last),   W'(el));
        chk("remaining",  W'(remaining),  W'(rem));
        chk("load_ready", W'(load_ready), W'(elr));
        if (ev && out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    // Reset for two edges, then every cycle is checked.
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    idle(2);

    // Natural order, then bit-reversed order.
    step(1'b1, 1'b0, mk_seq(32'h10), 1'b1, 1'b0, 1'b1);
    idle(DEPTH + 1);
    step(1'b1, 1'b1, mk_seq(32'h10), 1'b1, 1'b0, 1'b1);
    idle(DEPTH + 1);

    // Backpressure: hold the second word for three cycles.
    step(1'b1, 1'b0, mk_seq(32'h10), 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle(DEPTH);

    // Back-to-back: B waits with load_valid high until A's last word.
    step(1'b1, 1'b0, mk_seq(32'hA0), 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, mk_seq(32'hB0), 1'b1, 1'b0, 1'b1);
    idle(DEPTH + 1);

    // Flush at the 4th word with a competing load, then the same with reset.
    step(1'b1, 1'b0, mk_seq(32'h20), 1'b1, 1'b0, 1'b1);
    idle(3);
    step(1'b1, 1'b0, mk_seq(32'h30), 1'b1, 1'b1, 1'b1);
    idle(3);
    step(1'b1, 1'b0, mk_seq(32'h40), 1'b1, 1'b0, 1'b1);
    idle(3);
    step(1'b1, 1'b0, mk_seq(32'h50), 1'b1, 1'b0, 1'b0);
    idle(3);

    // Randomized traffic with backpressure, flushes and resets.
    for (int i = 0; i < 3000; i++) begin
      bit lv, br, ord, fl, rs;
      lv  = ($urandom_range(0, 99) < 35);
      br  = $urandom_range(0, 1) == 1;
      ord = ($urandom_range(0, 99) < 75);
      fl  = ($urandom_range(0, 99) < 2);
      rs  = !($urandom_range(0, 99) < 1);
      step(lv, br, mk_rand(), ord, fl, rs);
    end
    idle(DEPTH + 2);
    chk("drain", W'(q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
